// File: rtl/gpio_pkg.sv
// Register map and field widths shared by the GPIO input conditioner.
package gpio_pkg;
  localparam logic [7:0] ADDR_DATA    = 8'h00;
  localparam logic [7:0] ADDR_RISE_EN = 8'h04;
  localparam logic [7:0] ADDR_FALL_EN = 8'h08;
  localparam logic [7:0] ADDR_IRQ_EN  = 8'h0C;
  localparam logic [7:0] ADDR_STATUS  = 8'h10;
  localparam logic [7:0] ADDR_DIV     = 8'h14;
  localparam int         DIV_W        = 16;
endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: 2-flop synchronizer, tick-gated debounce counter and clean level.
module gpio_debounce_bit #(
  parameter int STABLE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  input  logic tick_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(STABLE);

  logic          meta_q, sync_q, clean_q, clean_d, accept;
  logic [CW-1:0] dcnt_q, dcnt_d;

  // A new level is taken on the STABLE-th consecutive differing tick.
  assign accept = tick_i && (sync_q != clean_q) && (dcnt_q == CW'(STABLE - 1));

  always_comb begin
    dcnt_d  = dcnt_q;
    clean_d = clean_q;
    if (tick_i) begin
      if (sync_q == clean_q) begin
        dcnt_d = '0;
      end else if (accept) begin
        clean_d = sync_q;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      clean_q <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      meta_q  <= pin_i;
      sync_q  <= meta_q;
      clean_q <= clean_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = accept &  sync_q;
  assign fall_o  = accept & ~sync_q;
endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input stage: prescaled per-bit debounce, edge capture into W1C STATUS, level irq.
module gpio_in_conditioner
  import gpio_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STABLE    = 4,
  parameter int DIV_RESET = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_pin_i,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [7:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic [WIDTH-1:0] gpio_clean_o,
  output logic             irq_o
);
  logic [DIV_W-1:0] div_q, cnt_q, cnt_d;
  logic [WIDTH-1:0] rise_en_q, fall_en_q, irq_en_q, status_q, status_d;
  logic [WIDTH-1:0] clean, rise, fall, clr;
  logic             tick, irq_q;
  logic             wr_rise, wr_fall, wr_irq, wr_stat, wr_div;

  assign wr_rise = wr_en_i && (addr_i == ADDR_RISE_EN);
  assign wr_fall = wr_en_i && (addr_i == ADDR_FALL_EN);
  assign wr_irq  = wr_en_i && (addr_i == ADDR_IRQ_EN);
  assign wr_stat = wr_en_i && (addr_i == ADDR_STATUS);
  assign wr_div  = wr_en_i && (addr_i == ADDR_DIV);

  // Writing DIV restarts the prescaler so the new period starts cleanly.
  assign tick  = (cnt_q == div_q);
  assign cnt_d = (wr_div || tick) ? '0 : cnt_q + 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(.STABLE(STABLE)) u_db (
      .clk    (clk),
      .rst_n  (rst_n),
      .pin_i  (gpio_pin_i[i]),
      .tick_i (tick),
      .clean_o(clean[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  // Same-cycle capture beats the W1C clear.
  assign clr      = wr_stat ? wdata_i[WIDTH-1:0] : '0;
  assign status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= DIV_W'(DIV_RESET);
      cnt_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_en_q  <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      status_q <= status_d;
      irq_q    <= |(status_q & irq_en_q);
      if (wr_div)  div_q     <= wdata_i[DIV_W-1:0];
      if (wr_rise) rise_en_q <= wdata_i[WIDTH-1:0];
      if (wr_fall) fall_en_q <= wdata_i[WIDTH-1:0];
      if (wr_irq)  irq_en_q  <= wdata_i[WIDTH-1:0];
    end
  end

  always_comb begin
    rdata_o = '0;
    if (rd_en_i) begin
      case (addr_i)
        ADDR_DATA:    rdata_o = 32'(clean);
        ADDR_RISE_EN: rdata_o = 32'(rise_en_q);
        ADDR_FALL_EN: rdata_o = 32'(fall_en_q);
        ADDR_IRQ_EN:  rdata_o = 32'(irq_en_q);
        ADDR_STATUS:  rdata_o = 32'(status_q);
        ADDR_DIV:     rdata_o = 32'(div_q);
        default:      rdata_o = '0;
      endcase
    end
  end

  assign gpio_clean_o = clean;
  assign irq_o        = irq_q;
endmodule
